// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction and mispredict detection.
// Optional BP_PERF_CNT_EN macro adds saturating resolved-branch and mispredict counters.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [1:0]        upd_kind,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(32'd1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

    // Saturating up/down step of a direction counter.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt, input logic up);
        logic [CNT_W-1:0] res;
        if (up) begin
            res = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        end else begin
            res = (cnt == CNT_ZERO) ? cnt : cnt - CNT_ONE;
        end
        return res;
    endfunction

    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [ADDR_W-1:0] target_r[ENTRIES];
    logic             jump_r   [ENTRIES];
    logic [CNT_W-1:0] cnt_r    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic              lk_hit_s;
    logic              lk_taken_s;
    logic [IDX_W-1:0]  up_idx_s;
    logic [TAG_W-1:0]  up_tag_s;
    logic              up_jump_s;
    logic              up_taken_s;
    logic              up_hit_s;
    logic              up_write_s;
    logic [CNT_W-1:0]  cnt_new_s;
    logic [ADDR_W-1:0] actual_next_s;
    logic              unused_s;

    assign lk_idx_s = if_pc[IDX_W+1:2];
    assign lk_tag_s = if_pc[ADDR_W-1:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_s = upd_pred_taken;

    // Fetch-side lookup against the registered table (no bypass of a same-cycle update).
    always_comb begin
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken_s = lk_hit_s && (jump_r[lk_idx_s] || cnt_r[lk_idx_s][CNT_W-1]);
        if (lk_taken_s) begin
            pred_target = target_r[lk_idx_s];
        end else begin
            pred_target = if_pc + PC_STEP;
        end
    end

    assign pred_hit   = lk_hit_s;
    assign pred_taken = lk_taken_s;

    // Resolve the reported instruction and work out the training write.
    always_comb begin
        case (upd_kind)
            2'b01, 2'b10: up_jump_s = 1'b1;
            default:      up_jump_s = 1'b0;
        endcase
        up_taken_s    = up_jump_s | upd_taken;
        actual_next_s = up_taken_s ? upd_target : upd_pc + PC_STEP;
        up_hit_s      = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        if (up_hit_s) begin
            cnt_new_s = cnt_step(cnt_r[up_idx_s], up_taken_s);
        end else if (up_jump_s) begin
            cnt_new_s = CNT_MAX;
        end else begin
            cnt_new_s = CNT_WT;
        end
        up_write_s = upd_valid & (up_hit_s | up_taken_s);
    end

    // Comparing next PCs catches both a wrong direction and a wrong target.
    assign mispredict  = upd_valid & (actual_next_s != upd_pred_target);
    assign redirect_pc = upd_valid ? actual_next_s : {ADDR_W{1'b0}};

    // Table state: reset, whole-table flush, or single-entry training.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {ADDR_W{1'b0}};
                jump_r[i]   <= 1'b0;
                cnt_r[i]    <= CNT_WNT;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (up_write_s) begin
            valid_r[up_idx_s] <= 1'b1;
            tag_r[up_idx_s]   <= up_tag_s;
            jump_r[up_idx_s]  <= up_jump_s;
            cnt_r[up_idx_s]   <= cnt_new_s;
            if (up_taken_s) begin
                target_r[up_idx_s] <= upd_target;
            end else begin
                target_r[up_idx_s] <= target_r[up_idx_s];
            end
        end else begin
            valid_r[up_idx_s] <= valid_r[up_idx_s];
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_r;
    logic [31:0] perf_mp_r;

    // Saturating event counters; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_r <= 32'h0000_0000;
            perf_mp_r <= 32'h0000_0000;
        end else begin
            if (upd_valid && (perf_br_r != 32'hFFFF_FFFF)) begin
                perf_br_r <= perf_br_r + 32'h0000_0001;
            end else begin
                perf_br_r <= perf_br_r;
            end
            if (mispredict && (perf_mp_r != 32'hFFFF_FFFF)) begin
                perf_mp_r <= perf_mp_r + 32'h0000_0001;
            end else begin
                perf_mp_r <= perf_mp_r;
            end
        end
    end

    assign perf_branches    = perf_br_r;
    assign perf_mispredicts = perf_mp_r;
`else
    assign perf_branches    = 32'h0000_0000;
    assign perf_mispredicts = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [1:0]  upd_kind;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches, perf_mispredicts;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_br = 32'h0;
    logic [31:0] exp_mp = 32'h0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_kind(upd_kind), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .flush_all(flush_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic hit, input logic tkn, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        check($sformatf("hit@%h", pc), {31'b0, pred_hit}, {31'b0, hit});
        check($sformatf("taken@%h", pc), {31'b0, pred_taken}, {31'b0, tkn});
        check($sformatf("target@%h", pc), pred_target, tgt);
    endtask

    task automatic do_upd(input logic [1:0] kind, input logic [31:0] pc, input logic tkn,
                          input logic [31:0] tgt, input logic [31:0] ptgt,
                          input logic exp_mis, input logic [31:0] exp_redir);
        upd_valid = 1'b1; upd_kind = kind; upd_pc = pc; upd_taken = tkn;
        upd_target = tgt; upd_pred_target = ptgt; upd_pred_taken = (ptgt != pc + 32'd4);
        #1;
        check($sformatf("mispredict@%h", pc), {31'b0, mispredict}, {31'b0, exp_mis});
        check($sformatf("redirect@%h", pc), redirect_pc, exp_redir);
        exp_br = exp_br + 32'd1;
        if (exp_mis) exp_mp = exp_mp + 32'd1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic check_perf(input string tag);
`ifdef BP_PERF_CNT_EN
        check({tag, "_br"}, perf_branches, exp_br);
        check({tag, "_mp"}, perf_mispredicts, exp_mp);
`else
        check({tag, "_br"}, perf_branches, 32'h0);
        check({tag, "_mp"}, perf_mispredicts, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h0; upd_valid = 1'b0; upd_kind = 2'b00; upd_pc = 32'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        flush_all = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        lookup(32'h100, 1'b0, 1'b0, 32'h104);
        check("mispredict_rst", {31'b0, mispredict}, 32'h0);
        check("redirect_idle", redirect_pc, 32'h0);
        check_perf("perf_rst");
        lookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // first allocation, no same-cycle bypass
        if_pc = 32'h100;
        upd_valid = 1'b1; upd_kind = 2'b00; upd_pc = 32'h100; upd_taken = 1'b1;
        upd_target = 32'h80; upd_pred_target = 32'h104; upd_pred_taken = 1'b0;
        #1;
        check("no_bypass_hit", {31'b0, pred_hit}, 32'h0);
        check("alloc_mispredict", {31'b0, mispredict}, 32'h1);
        check("alloc_redirect", redirect_pc, 32'h80);
        exp_br = exp_br + 32'd1; exp_mp = exp_mp + 32'd1;
        @(posedge clk); #1; upd_valid = 1'b0;
        lookup(32'h100, 1'b1, 1'b1, 32'h80);
        check("redirect_zero", redirect_pc, 32'h0);

        // counter training 10 -> 01 -> 00 -> 00 (saturate)
        do_upd(2'b00, 32'h100, 1'b0, 32'h80, 32'h80, 1'b1, 32'h104);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        do_upd(2'b00, 32'h100, 1'b0, 32'h80, 32'h104, 1'b0, 32'h104);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        do_upd(2'b00, 32'h100, 1'b0, 32'h80, 32'h104, 1'b0, 32'h104);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        // 00 -> 01 (still not taken) -> 10 (taken)
        do_upd(2'b00, 32'h100, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
        lookup(32'h100, 1'b1, 1'b0, 32'h104);
        do_upd(2'b00, 32'h100, 1'b1, 32'h88, 32'h104, 1'b1, 32'h88);
        lookup(32'h100, 1'b1, 1'b1, 32'h88);

        // aliasing at index 0
        lookup(32'h140, 1'b0, 1'b0, 32'h144);
        do_upd(2'b00, 32'h140, 1'b1, 32'h40, 32'h144, 1'b1, 32'h40);
        lookup(32'h140, 1'b1, 1'b1, 32'h40);
        lookup(32'h100, 1'b0, 1'b0, 32'h104);

        // jal allocates saturated, pin direction ignored
        do_upd(2'b01, 32'h200, 1'b0, 32'h300, 32'h204, 1'b1, 32'h300);
        lookup(32'h200, 1'b1, 1'b1, 32'h300);
        do_upd(2'b01, 32'h200, 1'b0, 32'h300, 32'h300, 1'b0, 32'h300);
        // kind rewritten to branch: 11 -> 10 keeps taken, 10 -> 01 drops it
        do_upd(2'b00, 32'h200, 1'b0, 32'h300, 32'h300, 1'b1, 32'h204);
        lookup(32'h200, 1'b1, 1'b1, 32'h300);
        do_upd(2'b00, 32'h200, 1'b0, 32'h300, 32'h300, 1'b1, 32'h204);
        lookup(32'h200, 1'b1, 1'b0, 32'h204);

        // jalr always taken; kind 11 behaves as a not-taken branch with no allocation
        do_upd(2'b10, 32'h204, 1'b0, 32'h500, 32'h208, 1'b1, 32'h500);
        lookup(32'h204, 1'b1, 1'b1, 32'h500);
        do_upd(2'b11, 32'h208, 1'b0, 32'h700, 32'h20C, 1'b0, 32'h20C);
        lookup(32'h208, 1'b0, 1'b0, 32'h20C);
        check_perf("perf_mid");

        // flush with concurrent update: update dropped, outputs still resolve
        flush_all = 1'b1;
        upd_valid = 1'b1; upd_kind = 2'b00; upd_pc = 32'h400; upd_taken = 1'b1;
        upd_target = 32'h600; upd_pred_target = 32'h404; upd_pred_taken = 1'b0;
        #1;
        check("flush_mispredict", {31'b0, mispredict}, 32'h1);
        check("flush_redirect", redirect_pc, 32'h600);
        exp_br = exp_br + 32'd1; exp_mp = exp_mp + 32'd1;
        @(posedge clk); #1; upd_valid = 1'b0; flush_all = 1'b0;
        lookup(32'h400, 1'b0, 1'b0, 32'h404);
        lookup(32'h140, 1'b0, 1'b0, 32'h144);
        lookup(32'h204, 1'b0, 1'b0, 32'h208);
        check_perf("perf_flush");

        // table usable again, then reset drops an in-flight update
        do_upd(2'b00, 32'h140, 1'b1, 32'h44, 32'h144, 1'b1, 32'h44);
        lookup(32'h140, 1'b1, 1'b1, 32'h44);
        rst = 1'b1;
        upd_valid = 1'b1; upd_kind = 2'b01; upd_pc = 32'h400; upd_taken = 1'b1;
        upd_target = 32'h600; upd_pred_target = 32'h404;
        @(posedge clk); #1; rst = 1'b0; upd_valid = 1'b0;
        exp_br = 32'h0; exp_mp = 32'h0;
        lookup(32'h400, 1'b0, 1'b0, 32'h404);
        lookup(32'h140, 1'b0, 1'b0, 32'h144);
        check_perf("perf_rst2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
